// File: rtl/sisc_pkg.sv
// Shared encodings for the SISC ALU / branch / control slice: opcodes, ALU
// functions, control states and status-flag bit positions.
package sisc_pkg;

  localparam int SISC_XLEN = 32;
  localparam int SISC_ALEN = 16;

  typedef enum logic [3:0] {
    OP_NOOP   = 4'h0,
    OP_REG_OP = 4'h1,
    OP_REG_IM = 4'h2,
    OP_BRA    = 4'h4,
    OP_BRR    = 4'h5,
    OP_BNE    = 4'h6,
    OP_BNR    = 4'h7,
    OP_HLT    = 4'hF
  } opcode_e;

  typedef enum logic [3:0] {
    FN_ADD = 4'h0,
    FN_SUB = 4'h1,
    FN_AND = 4'h2,
    FN_OR  = 4'h3,
    FN_XOR = 4'h4,
    FN_NOT = 4'h5,
    FN_SHL = 4'h6,
    FN_SHR = 4'h7
  } alu_fn_e;

  typedef enum logic [1:0] {
    ALU_RR   = 2'b00,
    ALU_RI   = 2'b01,
    ALU_IDLE = 2'b10
  } alu_op_e;

  typedef enum logic [2:0] {
    S_START0,
    S_START1,
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_MEM,
    S_WRITEBACK,
    S_HALT
  } state_e;

  // Status word layout {C,V,N,Z}
  localparam int FLAG_C = 3;
  localparam int FLAG_V = 2;
  localparam int FLAG_N = 1;
  localparam int FLAG_Z = 0;

endpackage

// File: rtl/sisc_alu_core.sv
// Combinational ALU with {C,V,N,Z} flag generation; operand B is either the
// register-file value or the zero-extended 16-bit immediate.
module sisc_alu_core
  import sisc_pkg::*;
#(
  parameter int DATA_W = SISC_XLEN
) (
  input  logic [1:0]        alu_op_i,
  input  logic [3:0]        fn_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_reg_i,
  input  logic [15:0]       imm_i,
  output logic [DATA_W-1:0] result_o,
  output logic [3:0]        flags_o
);

  logic signed [DATA_W-1:0] op_a;
  logic signed [DATA_W-1:0] op_b;
  logic signed [DATA_W-1:0] res;
  logic        [DATA_W:0]   sum_ext;
  logic                     carry;
  logic                     ovf;

  // Two same-signed addends producing a differently-signed sum overflowed;
  // subtraction reuses this with the inverted subtrahend.
  function automatic logic add_ovf(input logic signed [DATA_W-1:0] a,
                                   input logic signed [DATA_W-1:0] b,
                                   input logic signed [DATA_W-1:0] r);
    return (a[DATA_W-1] == b[DATA_W-1]) && (r[DATA_W-1] != a[DATA_W-1]);
  endfunction

  always_comb begin
    op_a    = a_i;
    op_b    = (alu_op_i == ALU_RR) ? b_reg_i : DATA_W'(imm_i);
    sum_ext = '0;
    res     = '0;
    carry   = 1'b0;
    ovf     = 1'b0;
    case (fn_i)
      FN_ADD: begin
        sum_ext = {1'b0, op_a} + {1'b0, op_b};
        res     = sum_ext[DATA_W-1:0];
        carry   = sum_ext[DATA_W];
        ovf     = add_ovf(op_a, op_b, res);
      end
      FN_SUB: begin
        sum_ext = {1'b0, op_a} + {1'b0, ~op_b} + (DATA_W+1)'(1);
        res     = sum_ext[DATA_W-1:0];
        carry   = sum_ext[DATA_W];
        ovf     = add_ovf(op_a, ~op_b, res);
      end
      FN_AND:  res = op_a & op_b;
      FN_OR:   res = op_a | op_b;
      FN_XOR:  res = op_a ^ op_b;
      FN_NOT:  res = ~op_a;
      FN_SHL:  res = {op_a[DATA_W-2:0], 1'b0};
      FN_SHR:  res = {1'b0, op_a[DATA_W-1:1]};
      default: res = '0;
    endcase
  end

  always_comb begin
    flags_o         = '0;
    flags_o[FLAG_C] = carry;
    flags_o[FLAG_V] = ovf;
    flags_o[FLAG_N] = res[DATA_W-1];
    flags_o[FLAG_Z] = (res == '0);
  end

  assign result_o = res;

endmodule

// File: rtl/alu_br_ctrl.sv
// SISC execute slice: ALU, branch-target adder and the multi-cycle control
// FSM that sequences fetch/decode/execute/mem/writeback strobes.
module alu_br_ctrl
  import sisc_pkg::*;
(
  input  logic        clk,
  input  logic        rst_f,
  input  logic [31:0] instr,
  input  logic [3:0]  stat,
  input  logic [31:0] rsa,
  input  logic [31:0] rsb,
  input  logic [15:0] pc,
  output logic [31:0] alu_result,
  output logic [3:0]  stat_out,
  output logic        stat_en,
  output logic [15:0] br_addr,
  output logic        rf_we,
  output logic        wb_sel,
  output logic        rb_sel,
  output logic        br_sel,
  output logic        ir_load,
  output logic        pc_sel,
  output logic        pc_write,
  output logic        pc_rst,
  output logic [1:0]  alu_op
);

  state_e      state_q;
  state_e      state_d;
  logic [3:0]  opcode;
  logic [3:0]  mm;
  logic [15:0] imm;
  logic        is_alu;
  logic        br_taken;
  logic        unused_regs;

  assign opcode      = instr[31:28];
  assign mm          = instr[27:24];
  assign imm         = instr[15:0];
  // rd/rs are consumed by the register file, not here
  assign unused_regs = ^instr[23:16];
  assign is_alu      = (opcode == OP_REG_OP) || (opcode == OP_REG_IM);

  always_comb begin
    br_taken = 1'b0;
    case (opcode)
      OP_BRA, OP_BRR: br_taken = |(stat & mm);
      OP_BNE, OP_BNR: br_taken = ~|(stat & mm);
      default:        br_taken = 1'b0;
    endcase
  end

  sisc_alu_core #(
    .DATA_W (SISC_XLEN)
  ) u_alu (
    .alu_op_i (alu_op),
    .fn_i     (mm),
    .a_i      (rsa),
    .b_reg_i  (rsb),
    .imm_i    (imm),
    .result_o (alu_result),
    .flags_o  (stat_out)
  );

  // pc arrives already incremented by FETCH; the sum wraps at 16 bits
  assign br_addr = br_sel ? imm : (pc + imm);

  always_ff @(posedge clk) begin
    if (rst_f) state_q <= S_START0;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_START0:    state_d = S_START1;
      S_START1:    state_d = S_FETCH;
      S_FETCH:     state_d = S_DECODE;
      S_DECODE:    state_d = (opcode == OP_HLT) ? S_HALT : S_EXECUTE;
      S_EXECUTE:   state_d = S_MEM;
      S_MEM:       state_d = S_WRITEBACK;
      S_WRITEBACK: state_d = S_FETCH;
      S_HALT:      state_d = S_HALT;
      default:     state_d = S_START0;
    endcase
  end

  // Reset overrides the decoded state so strobes are safe before the first edge
  always_comb begin
    stat_en  = 1'b0;
    rf_we    = 1'b0;
    wb_sel   = 1'b0;
    rb_sel   = 1'b0;
    br_sel   = 1'b0;
    ir_load  = 1'b0;
    pc_sel   = 1'b0;
    pc_write = 1'b0;
    pc_rst   = 1'b0;
    alu_op   = ALU_IDLE;
    if (rst_f) begin
      pc_rst = 1'b1;
    end else begin
      case (state_q)
        S_START0, S_START1: pc_rst = 1'b1;
        S_FETCH: begin
          ir_load  = 1'b1;
          pc_write = 1'b1;
        end
        S_DECODE: begin
          if (br_taken) begin
            pc_write = 1'b1;
            pc_sel   = 1'b1;
            br_sel   = (opcode == OP_BRA) || (opcode == OP_BNE);
          end
        end
        S_EXECUTE: begin
          if (is_alu) begin
            alu_op  = (opcode == OP_REG_OP) ? ALU_RR : ALU_RI;
            stat_en = 1'b1;
          end
        end
        // alu_op stays put through MEM so the result is stable for writeback
        S_MEM: begin
          if (is_alu) alu_op = (opcode == OP_REG_OP) ? ALU_RR : ALU_RI;
        end
        S_WRITEBACK: begin
          if (is_alu) begin
            alu_op = (opcode == OP_REG_OP) ? ALU_RR : ALU_RI;
            rf_we  = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_br_ctrl.sv
// Scoreboard bench for alu_br_ctrl: expected per-cycle strobes and data are
// queued when an instruction is driven and compared on the falling edge.
module tb_alu_br_ctrl;

  localparam int T_RST = 0, T_S0 = 1, T_S1 = 2, T_FE = 3, T_DE = 4,
                 T_EX = 5, T_ME = 6, T_WB = 7, T_HALT = 8;

  logic        clk = 1'b0;
  logic        rst_f = 1'b1;
  logic [31:0] instr = '0;
  logic [3:0]  stat = '0;
  logic [31:0] rsa = '0;
  logic [31:0] rsb = '0;
  logic [15:0] pc = '0;
  logic [31:0] alu_result;
  logic [3:0]  stat_out;
  logic        stat_en;
  logic [15:0] br_addr;
  logic        rf_we, wb_sel, rb_sel, br_sel, ir_load, pc_sel, pc_write, pc_rst;
  logic [1:0]  alu_op;
  logic [10:0] obs_strb;

  typedef struct {
    string       tag;
    logic [10:0] strb;
    bit          chk_alu;
    logic [31:0] res;
    logic [3:0]  flg;
    bit          chk_br;
    logic [15:0] br;
  } exp_t;

  exp_t  sb[$];
  int    n_chk  = 0;
  int    n_pass = 0;
  string cur_name = "";
  string st_nm[9] = '{"rst", "start0", "start1", "fetch", "decode",
                      "execute", "mem", "writeback", "halt"};

  alu_br_ctrl dut (
    .clk        (clk),
    .rst_f      (rst_f),
    .instr      (instr),
    .stat       (stat),
    .rsa        (rsa),
    .rsb        (rsb),
    .pc         (pc),
    .alu_result (alu_result),
    .stat_out   (stat_out),
    .stat_en    (stat_en),
    .br_addr    (br_addr),
    .rf_we      (rf_we),
    .wb_sel     (wb_sel),
    .rb_sel     (rb_sel),
    .br_sel     (br_sel),
    .ir_load    (ir_load),
    .pc_sel     (pc_sel),
    .pc_write   (pc_write),
    .pc_rst     (pc_rst),
    .alu_op     (alu_op)
  );

  always #5 clk = ~clk;

  assign obs_strb = {pc_rst, ir_load, pc_write, pc_sel, br_sel, stat_en,
                     rf_we, wb_sel, rb_sel, alu_op};

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, passed %0d of %0d", n_pass, n_chk);
    $fatal(1, "watchdog");
  end

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [31:0] mk(input logic [3:0] op, input logic [3:0] m,
                                     input logic [15:0] im);
    return {op, m, 8'h00, im};
  endfunction

  // Returns {C,V,N,Z,result}
  function automatic logic [35:0] model_alu(input logic [3:0] m, input logic [31:0] a,
                                            input logic [31:0] b);
    logic [31:0] r;
    logic [32:0] w;
    bit          c, v;
    longint      sa, sbv, ss;
    r  = '0;
    c  = 1'b0;
    v  = 1'b0;
    sa  = longint'($signed(a));
    sbv = longint'($signed(b));
    case (m)
      4'd0: begin
        w = {1'b0, a} + {1'b0, b};
        r = w[31:0];
        c = w[32];
        ss = sa + sbv;
        v = (ss != longint'($signed(r)));
      end
      4'd1: begin
        w = {1'b0, a} + {1'b0, ~b} + 33'd1;
        r = a - b;
        c = w[32];
        ss = sa - sbv;
        v = (ss != longint'($signed(r)));
      end
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = a ^ b;
      4'd5: r = ~a;
      4'd6: r = a << 1;
      4'd7: r = a >> 1;
      default: r = '0;
    endcase
    return {c, v, r[31], (r == 32'd0), r};
  endfunction

  // Packed as {pc_rst, ir_load, pc_write, pc_sel, br_sel, stat_en, rf_we, wb_sel, rb_sel, alu_op}
  function automatic logic [10:0] exp_strb(input int st, input logic [3:0] op,
                                           input logic [3:0] m, input logic [3:0] s);
    bit pr, il, pw, ps, bs, se, we, alu, tk;
    logic [1:0] ao;
    pr = 0; il = 0; pw = 0; ps = 0; bs = 0; se = 0; we = 0;
    ao  = 2'b10;
    alu = (op == 4'h1) || (op == 4'h2);
    tk  = (((op == 4'h4) || (op == 4'h5)) && ((s & m) != 4'h0)) ||
          (((op == 4'h6) || (op == 4'h7)) && ((s & m) == 4'h0));
    case (st)
      T_RST, T_S0, T_S1: pr = 1;
      T_FE: begin il = 1; pw = 1; end
      T_DE: if (tk) begin pw = 1; ps = 1; bs = (op == 4'h4) || (op == 4'h6); end
      T_EX: if (alu) begin se = 1; ao = (op == 4'h1) ? 2'b00 : 2'b01; end
      T_ME: if (alu) ao = (op == 4'h1) ? 2'b00 : 2'b01;
      T_WB: if (alu) begin we = 1; ao = (op == 4'h1) ? 2'b00 : 2'b01; end
      default: ;
    endcase
    return {pr, il, pw, ps, bs, se, we, 1'b0, 1'b0, ao};
  endfunction

  task automatic push_state(input int st);
    exp_t        e;
    logic [3:0]  op, m;
    logic [15:0] im;
    op = instr[31:28];
    m  = instr[27:24];
    im = instr[15:0];
    e.tag     = {cur_name, "/", st_nm[st]};
    e.strb    = exp_strb(st, op, m, stat);
    e.chk_alu = ((st == T_EX) || (st == T_WB)) && ((op == 4'h1) || (op == 4'h2));
    {e.flg, e.res} = model_alu(m, rsa, (op == 4'h1) ? rsb : {16'h0, im});
    e.chk_br  = (st == T_DE) && (op >= 4'h4) && (op <= 4'h7);
    e.br      = e.strb[6] ? im : 16'(pc + im);
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    while (sb.size() != 0) begin
      @(negedge clk);
      e = sb.pop_front();
      chk_eq({e.tag, ".strobes"}, 32'(obs_strb), 32'(e.strb));
      if (e.chk_alu) begin
        chk_eq({e.tag, ".result"}, alu_result, e.res);
        chk_eq({e.tag, ".flags"}, 32'(stat_out), 32'(e.flg));
      end
      if (e.chk_br) chk_eq({e.tag, ".br_addr"}, 32'(br_addr), 32'(e.br));
    end
  endtask

  // Holds reset for n sampled cycles, then releases just after an edge so
  // START0 is the first full cycle out of reset.
  task automatic reset_pulse(input int n);
    cur_name = "reset";
    @(posedge clk);
    #1 rst_f = 1'b1;
    repeat (n) push_state(T_RST);
    drain();
    @(posedge clk);
    #1 rst_f = 1'b0;
    push_state(T_S0);
    push_state(T_S1);
  endtask

  task automatic run_instr(input string nm, input logic [31:0] ir, input logic [3:0] st,
                           input logic [31:0] a, input logic [31:0] b, input logic [15:0] p);
    cur_name = nm;
    instr = ir;
    stat  = st;
    rsa   = a;
    rsb   = b;
    pc    = p;
    for (int s = T_FE; s <= T_WB; s++) push_state(s);
    drain();
  endtask

  initial begin
    reset_pulse(2);
    run_instr("add_wrap", mk(4'h1, 4'h0, 16'h0000), 4'h0, 32'hFFFF_FFFF, 32'h1, 16'h0001);
    run_instr("subi", mk(4'h2, 4'h1, 16'hFFFF), 4'h0, 32'h7FFF_FFFF, 32'h0, 16'h0002);
    run_instr("add_ovf", mk(4'h1, 4'h0, 16'h0), 4'h0, 32'h7FFF_FFFF, 32'h1, 16'h0003);
    run_instr("sub_borrow", mk(4'h1, 4'h1, 16'h0), 4'h0, 32'h0, 32'h1, 16'h0004);
    run_instr("sub_ovf", mk(4'h1, 4'h1, 16'h0), 4'h0, 32'h8000_0000, 32'h1, 16'h0005);
    for (int m = 0; m < 16; m++)
      run_instr($sformatf("rr_fn%0d", m), mk(4'h1, 4'(m), 16'h0), 4'h0,
                $urandom, $urandom, 16'h0100);
    run_instr("ori", mk(4'h2, 4'h3, 16'hA5A5), 4'h0, 32'h1234_0000, 32'hFFFF_FFFF, 16'h0200);
    run_instr("brr_tk", mk(4'h5, 4'h1, 16'hFFFE), 4'h1, 32'h0, 32'h0, 16'h0010);
    run_instr("brr_nt", mk(4'h5, 4'h1, 16'hFFFE), 4'h0, 32'h0, 32'h0, 16'h0010);
    run_instr("bne_tk", mk(4'h6, 4'h1, 16'h0040), 4'h0, 32'h0, 32'h0, 16'h0020);
    run_instr("bne_nt", mk(4'h6, 4'h1, 16'h0040), 4'h1, 32'h0, 32'h0, 16'h0020);
    run_instr("bra_tk", mk(4'h4, 4'h8, 16'h1234), 4'h9, 32'h0, 32'h0, 16'h0030);
    run_instr("bnr_wrap", mk(4'h7, 4'h2, 16'h0020), 4'h1, 32'h0, 32'h0, 16'hFFF0);
    run_instr("op3_noop", mk(4'h3, 4'h0, 16'h0001), 4'hF, 32'h5, 32'h6, 16'h0040);
    run_instr("noop", mk(4'h0, 4'h0, 16'h0), 4'h0, 32'h0, 32'h0, 16'h0041);

    // Reset landing in the middle of EXECUTE
    cur_name = "midrst";
    instr = mk(4'h1, 4'h0, 16'h0);
    rsa = 32'h10;
    rsb = 32'h20;
    push_state(T_FE);
    push_state(T_DE);
    drain();
    reset_pulse(1);
    run_instr("after_midrst", mk(4'h2, 4'h4, 16'h00FF), 4'h0, 32'hFFFF_0F0F, 32'h0, 16'h0050);

    // Halt is absorbing until reset
    cur_name = "hlt";
    instr = mk(4'hF, 4'h0, 16'h0);
    stat  = 4'hF;
    push_state(T_FE);
    push_state(T_DE);
    repeat (20) push_state(T_HALT);
    drain();
    reset_pulse(1);
    run_instr("after_hlt", mk(4'h1, 4'h2, 16'h0), 4'h0, 32'hF0F0_F0F0, 32'hFF00_FF00, 16'h0060);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
